// File: rtl/dm_arbiter.sv
// Two-port arbiter and one-access-at-a-time sequencer in front of the byte-addressed data memory.
// Port 0 is the CPU MEM stage, port 1 the debug/loader; illegal accesses are acked with err and never reach memory.
`timescale 1ns/1ps

module dm_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [2:0]        m0_type,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m1_type,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    output logic [2:0]        dm_type,
    input  logic [DATA_W-1:0] dm_dout
);

    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

    state_t              state_reg, state_next;
    logic                last_reg;
    logic                sel_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [2:0]          type_reg;
    logic                legal_reg;
    logic                err_reg;
    logic [DATA_W-1:0]   rdata_reg [2];
    logic [1:0]          ack_vec;

    logic                grant;
    logic                win;
    logic                pick_we;
    logic [ADDR_W-1:0]   pick_addr;
    logic [DATA_W-1:0]   pick_wdata;
    logic [2:0]          pick_type;
    logic                pick_legal;

    assign grant = m0_req | m1_req;

    always_comb begin
        win = 1'b0;
        if (m0_req && m1_req) begin
            win = RR_EN ? ~last_reg : 1'b0;
        end else if (m1_req) begin
            win = 1'b1;
        end
    end

    assign pick_we    = win ? m1_we    : m0_we;
    assign pick_addr  = win ? m1_addr  : m0_addr;
    assign pick_wdata = win ? m1_wdata : m0_wdata;
    assign pick_type  = win ? m1_type  : m0_type;

    // Unknown type, misaligned word/half, or a store with a load-only (unsigned) type.
    always_comb begin
        pick_legal = 1'b1;
        if (pick_type >= 3'd5)
            pick_legal = 1'b0;
        if ((pick_type == 3'd0) && (pick_addr[1:0] != 2'b00))
            pick_legal = 1'b0;
        if (((pick_type == 3'd1) || (pick_type == 3'd2)) && pick_addr[0])
            pick_legal = 1'b0;
        if (pick_we && ((pick_type == 3'd2) || (pick_type == 3'd4)))
            pick_legal = 1'b0;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = SERVE;
            SERVE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            sel_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            type_reg  <= 3'd0;
            legal_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        sel_reg   <= win;
                        we_reg    <= pick_we;
                        addr_reg  <= pick_addr;
                        wdata_reg <= pick_wdata;
                        type_reg  <= pick_type;
                        legal_reg <= pick_legal;
                    end
                end
                SERVE: begin
                    err_reg  <= ~legal_reg;
                    last_reg <= sel_reg;
                end
                default: ;
            endcase
        end
    end

    // Per-port read data holds between acks; only the owning port's register updates.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rdata_reg[gi] <= '0;
            end else if ((state_reg == SERVE) && (sel_reg == 1'(gi))) begin
                rdata_reg[gi] <= (legal_reg && !we_reg) ? dm_dout : '0;
            end
        end
        assign ack_vec[gi] = (state_reg == RESP) && (sel_reg == 1'(gi));
    end

    assign m0_ack   = ack_vec[0];
    assign m1_ack   = ack_vec[1];
    assign m0_err   = ack_vec[0] & err_reg;
    assign m1_err   = ack_vec[1] & err_reg;
    assign m0_rdata = rdata_reg[0];
    assign m1_rdata = rdata_reg[1];

    // State resets asynchronously, so a write in flight is dropped the moment rstn falls.
    assign dm_wr   = (state_reg == SERVE) & we_reg & legal_reg;
    assign dm_addr = addr_reg;
    assign dm_din  = wdata_reg;
    assign dm_type = type_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: round-robin and fixed-priority instances share the request inputs,
// the round-robin one drives a byte-array memory model.
`timescale 1ns/1ps

module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [5:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [2:0]  m0_type, m1_type;

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dm_wr;
    logic [5:0]  dm_addr;
    logic [31:0] dm_din, dm_dout;
    logic [2:0]  dm_type;

    logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_dm_wr;
    logic [5:0]  fp_dm_addr;
    logic [31:0] fp_dm_din;
    logic [31:0] fp_dm_dout = 32'h0;
    logic [2:0]  fp_dm_type;

    logic [7:0]  mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(6), .DATA_W(32), .RR_EN(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_type(m0_type),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_type(m1_type),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din), .dm_type(dm_type), .dm_dout(dm_dout)
    );

    dm_arbiter #(.ADDR_W(6), .DATA_W(32), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_type(m0_type),
        .m0_ack(fp_m0_ack), .m0_err(fp_m0_err), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_type(m1_type),
        .m1_ack(fp_m1_ack), .m1_err(fp_m1_err), .m1_rdata(fp_m1_rdata),
        .dm_wr(fp_dm_wr), .dm_addr(fp_dm_addr), .dm_din(fp_dm_din), .dm_type(fp_dm_type),
        .dm_dout(fp_dm_dout)
    );

    // Memory model: little-endian, combinational read with sign/zero extension per DMType.
    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[dm_addr];
        b1 = mem[dm_addr + 6'd1];
        b2 = mem[dm_addr + 6'd2];
        b3 = mem[dm_addr + 6'd3];
        case (dm_type)
            3'd0:    dm_dout = {b3, b2, b1, b0};
            3'd1:    dm_dout = {{16{b1[7]}}, b1, b0};
            3'd2:    dm_dout = {16'h0, b1, b0};
            3'd3:    dm_dout = {{24{b0[7]}}, b0};
            3'd4:    dm_dout = {24'h0, b0};
            default: dm_dout = 32'h0;
        endcase
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    end

    always @(posedge clk) begin
        if (dm_wr) begin
            case (dm_type)
                3'd0: begin
                    mem[dm_addr]        <= dm_din[7:0];
                    mem[dm_addr + 6'd1] <= dm_din[15:8];
                    mem[dm_addr + 6'd2] <= dm_din[23:16];
                    mem[dm_addr + 6'd3] <= dm_din[31:24];
                end
                3'd1, 3'd2: begin
                    mem[dm_addr]        <= dm_din[7:0];
                    mem[dm_addr + 6'd1] <= dm_din[15:8];
                end
                default: mem[dm_addr] <= dm_din[7:0];
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one access on one port, hold it until its ack (bounded), then drop req.
    task automatic do_access(input logic p, input logic we, input logic [5:0] a,
                             input logic [31:0] wd, input logic [2:0] t,
                             output int lat, output logic e, output logic [31:0] rd,
                             output logic wrs);
        @(posedge clk); #1;
        if (!p) begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = wd; m0_type = t;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd; m1_type = t;
        end
        lat = -1; e = 1'b0; rd = 32'h0; wrs = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (dm_wr) wrs = 1'b1;
            if (p ? m1_ack : m0_ack) begin
                lat = c;
                e   = p ? m1_err : m0_err;
                rd  = p ? m1_rdata : m0_rdata;
                break;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        $display("txn port=%0d we=%0d addr=%0d type=%0d wdata=%h -> lat=%0d err=%0d rdata=%h",
                 p, we, a, t, wd, lat, e, rd);
    endtask

    initial begin
        int          lat;
        logic        e, w;
        logic [31:0] rd, snap;
        int          nack, overlap, fp0, fp1, first_port, m1_lat;
        int          order [4];

        rstn = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_type = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_type = '0;
        @(negedge clk);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(m1_ack), 32'd0);
        chk("rst_errs", 32'({m0_err, m1_err}), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_dm", {dm_wr, dm_addr, dm_type, 22'h0}, 32'h0);
        chk("rst_dm_din", dm_din, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Word store then load at address 8.
        do_access(1'b0, 1'b1, 6'd8, 32'hDEADBEEF, 3'd0, lat, e, rd, w);
        chk("sw8_lat", 32'(lat), 32'd3);
        chk("sw8_err", 32'(e), 32'd0);
        chk("sw8_wr", 32'(w), 32'd1);
        chk("sw8_mem", {mem[11], mem[10], mem[9], mem[8]}, 32'hDEADBEEF);
        do_access(1'b0, 1'b0, 6'd8, 32'h0, 3'd0, lat, e, rd, w);
        chk("lw8_lat", 32'(lat), 32'd3);
        chk("lw8_rdata", rd, 32'hDEADBEEF);
        chk("lw8_err", 32'(e), 32'd0);
        chk("lw8_nowr", 32'(w), 32'd0);

        // Fairness: both ports load continuously for 12 cycles after a fresh reset.
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd0; m0_type = 3'd0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd4; m1_type = 3'd0;
        nack = 0; overlap = 0; fp0 = 0; fp1 = 0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (m0_ack && m1_ack) overlap++;
            if (m0_ack || m1_ack) begin
                if (nack < 4) order[nack] = m1_ack ? 1 : 0;
                nack++;
                $display("txn fairness ack port=%0d at cycle %0d", m1_ack ? 1 : 0, c);
            end
            if (fp_m0_ack) fp0++;
            if (fp_m1_ack) fp1++;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("rr_nack", 32'(nack), 32'd4);
        chk("rr_overlap", 32'(overlap), 32'd0);
        chk("rr_order0", 32'(order[0]), 32'd0);
        chk("rr_order1", 32'(order[1]), 32'd1);
        chk("rr_order2", 32'(order[2]), 32'd0);
        chk("rr_order3", 32'(order[3]), 32'd1);
        chk("rr_m0_rdata", m0_rdata, 32'h03020100);
        chk("rr_m1_rdata", m1_rdata, 32'h07060504);
        chk("fp_m0_acks", 32'(fp0), 32'd4);
        chk("fp_m1_acks", 32'(fp1), 32'd0);

        // Byte store by port 0, signed byte load by port 1.
        do_access(1'b0, 1'b1, 6'd5, 32'h00000080, 3'd3, lat, e, rd, w);
        chk("sb5_err", 32'(e), 32'd0);
        chk("sb5_mem", 32'(mem[5]), 32'h80);
        do_access(1'b1, 1'b0, 6'd5, 32'h0, 3'd3, lat, e, rd, w);
        chk("lb5_rdata", rd, 32'hFFFFFF80);
        chk("lb5_lat", 32'(lat), 32'd3);

        // Same-cycle requests after a port-1 grant: port 0 half store goes first.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd2; m0_wdata = 32'h00001234; m0_type = 3'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd2; m1_wdata = 32'h0;        m1_type = 3'd2;
        first_port = -1; m1_lat = -1; rd = 32'h0; e = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (first_port < 0 && (m0_ack || m1_ack)) first_port = m1_ack ? 1 : 0;
            if (m0_ack) m0_req = 1'b0;
            if (m1_ack) begin
                m1_lat = c; rd = m1_rdata; e = m1_err; m1_req = 1'b0;
                break;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        $display("txn contention first=%0d m1 ack cycle=%0d m1_rdata=%h", first_port, m1_lat, rd);
        chk("sh2_first", 32'(first_port), 32'd0);
        chk("lhu2_lat", 32'(m1_lat), 32'd6);
        chk("lhu2_rdata", rd, 32'h00001234);
        chk("lhu2_err", 32'(e), 32'd0);

        // Illegal accesses: error ack, no write, memory untouched.
        snap = {mem[9], mem[8], mem[7], mem[6]};
        do_access(1'b0, 1'b1, 6'd6, 32'hCAFEF00D, 3'd0, lat, e, rd, w);
        chk("sw6_err", 32'(e), 32'd1);
        chk("sw6_nowr", 32'(w), 32'd0);
        chk("sw6_rdata", rd, 32'h0);
        chk("sw6_lat", 32'(lat), 32'd3);
        chk("sw6_mem", {mem[9], mem[8], mem[7], mem[6]}, snap);
        do_access(1'b0, 1'b1, 6'd6, 32'h000000AA, 3'd4, lat, e, rd, w);
        chk("sbu6_err", 32'(e), 32'd1);
        chk("sbu6_nowr", 32'(w), 32'd0);
        do_access(1'b0, 1'b1, 6'd6, 32'h000000BB, 3'd7, lat, e, rd, w);
        chk("st7_err", 32'(e), 32'd1);
        chk("st7_nowr", 32'(w), 32'd0);
        chk("ill_mem", {mem[9], mem[8], mem[7], mem[6]}, snap);
        do_access(1'b0, 1'b1, 6'd4, 32'h000000CC, 3'd2, lat, e, rd, w);
        chk("shu4_err", 32'(e), 32'd1);
        do_access(1'b1, 1'b0, 6'd3, 32'h0, 3'd1, lat, e, rd, w);
        chk("lh3_err", 32'(e), 32'd1);
        chk("lh3_rdata", rd, 32'h0);
        do_access(1'b1, 1'b0, 6'd6, 32'h0, 3'd1, lat, e, rd, w);
        chk("lh6_err", 32'(e), 32'd0);
        chk("lh6_rdata", rd, 32'h00000706);

        // Aligned word at the top of memory.
        do_access(1'b0, 1'b1, 6'd60, 32'hA1B2C3D4, 3'd0, lat, e, rd, w);
        chk("sw60_err", 32'(e), 32'd0);
        chk("sw60_mem", {mem[63], mem[62], mem[61], mem[60]}, 32'hA1B2C3D4);
        do_access(1'b1, 1'b0, 6'd60, 32'h0, 3'd0, lat, e, rd, w);
        chk("lw60_rdata", rd, 32'hA1B2C3D4);

        // Reset asserted during SERVE of a word store to 16.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd16; m0_wdata = 32'h55AA55AA; m0_type = 3'd0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_serve_wr", 32'(dm_wr), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_wr", 32'(dm_wr), 32'd0);
        chk("mid_rst_ack", 32'(m0_ack), 32'd0);
        @(negedge clk);
        chk("mid_rst_ack2", 32'(m0_ack), 32'd0);
        m0_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("mid_rst_mem", {mem[19], mem[18], mem[17], mem[16]}, 32'h13121110);
        $display("txn reset during SERVE, mem[16..19]=%h", {mem[19], mem[18], mem[17], mem[16]});

        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd16; m0_type = 3'd0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd20; m1_type = 3'd0;
        first_port = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                first_port = m1_ack ? 1 : 0;
                break;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        $display("txn first grant after reset port=%0d m0_rdata=%h", first_port, m0_rdata);
        chk("post_rst_first", 32'(first_port), 32'd0);
        chk("post_rst_rdata", m0_rdata, 32'h13121110);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the byte-addressed data memory (dm).
- Port 0 serves the CPU MEM stage; port 1 serves the debug/loader.
- Grants one access at a time using round-robin priority and drives the dm write enable, address, data and DMType.
- Captures read data and returns it with a one-cycle ack pulse.
- Rejects misaligned or illegal accesses with an error ack and never touches memory for them.

Parameters:
- ADDR_W, 6: byte-address width (matches dm addr).
- DATA_W, 32: data width.
- RR_EN, 1: 1 = round-robin priority; 0 = fixed priority with port 0 highest.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- m0_req  in  1  port 0 request; held with its fields stable until m0_ack.
- m0_we  in  1  port 0 store (1) / load (0).
- m0_addr  in  ADDR_W  port 0 byte address.
- m0_wdata  in  DATA_W  port 0 store data.
- m0_type  in  3  port 0 access type: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
- m0_ack  out  1  port 0 one-cycle completion pulse.
- m0_err  out  1  port 0 error flag, valid with m0_ack.
- m0_rdata  out  DATA_W  port 0 load data, valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_type, m1_ack, m1_err, m1_rdata: same as port 0, for port 1.
- dm_wr  out  1  dm DMWr.
- dm_addr  out  ADDR_W  dm addr.
- dm_din  out  DATA_W  dm din.
- dm_type  out  3  dm DMType.
- dm_dout  in  DATA_W  dm dout (combinational read).

Behaviour:
- Reset (rstn=0, asynchronous):
  - state = IDLE; round-robin pointer last = 1, so port 0 wins first.
  - All ack and err outputs = 0; all rdata outputs = 0.
  - dm_wr = 0, dm_addr = 0, dm_din = 0, dm_type = 000.
- FSM states: IDLE, SERVE, RESP.
- IDLE:
  - No req asserted: stay in IDLE.
  - Any req asserted: pick the winner, latch its we/addr/wdata/type into internal registers, record sel, go to SERVE.
  - Both req, RR_EN=1: winner = port != last.
  - Both req, RR_EN=0: winner = port 0.
  - Legality check at latch time; illegal = any of:
    - type ≥ 101;
    - word with addr[1:0] != 00;
    - half/half-unsigned with addr[0] != 0;
    - store with type 010 or 100.
- SERVE (exactly one cycle):
  - dm_addr, dm_din and dm_type driven from the latched registers.
  - dm_wr = latched we AND legal; an illegal access never writes.
  - At the closing edge: rdata_q <= dm_dout for a legal load, else 0; err_q <= !legal; last <= sel. Go to RESP.
- RESP (exactly one cycle):
  - mSEL_ack = 1, mSEL_err = err_q, mSEL_rdata = rdata_q.
  - The other port's ack stays 0. dm_wr = 0. Next state is IDLE.
- Latency:
  - Request sampled at edge N; memory accessed during cycle N+1; write committed at edge N+2.
  - ack visible in cycle N+2. 3 cycles request-to-ack minimum.
  - Back-to-back: a request held through RESP is re-arbitrated in IDLE, so one access per 3 cycles per arbiter.
- Fairness: under continuous requests from both ports with RR_EN=1, grants strictly alternate 0,1,0,1…
- A requester deasserting req before ack is a protocol violation. The latched access still completes and is still acked.
- rdata outputs hold their last value between acks. Only the ack pulse qualifies them.
- dm_wr is never 1 outside SERVE.
- Reset mid-SERVE before the edge: no write occurs (dm_wr drops asynchronously); no ack is issued.
- Address wrap: no wrap logic here. Aligned word at max address 60 covers bytes 60–63.

Test Plan:
- Reset release, m0 word store addr=8 wdata=0xDEADBEEF, then load addr=8 → store ack in cycle 3 with err=0; load m0_rdata=0xDEADBEEF.
- Both ports request loads every cycle for 12 cycles with RR_EN=1 → grant order 0,1,0,1 with acks alternating m0_ack/m1_ack, never simultaneous. With RR_EN=0 → only m0 served while m0_req stays high.
- m1 byte load addr=5 after m0 byte store 0x80 to addr=5 → m1_rdata=0xFFFFFF80.
- m0 word store addr=6 → m0_ack with m0_err=1, dm_wr never 1, memory bytes 6–9 unchanged. Same for a store with type 100 and for type 111.
- m0 half store addr=2 data 0x1234 while m1 requests in the same cycle → m0 served first. m1 half load addr=2 then returns 0x00001234.
- Assert rstn=0 during SERVE of a word store to addr=16 → dm_wr drops immediately, no ack, bytes 16–19 keep their initial values 16,17,18,19; first grant after reset goes to m0.
